// File: rtl/lcd_spi_panel_rx_pkg.sv
// Shared opcodes, reset constants and decoder state type for the LCD SPI panel receiver.
package lcd_spi_panel_rx_pkg;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_INVOFF  = 8'h20;
  localparam logic [7:0] OP_INVON   = 8'h21;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_MADCTL  = 8'h36;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;

  localparam logic [7:0] COLMOD_RST = 8'h66;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARGS   = 2'd1,
    ST_RAM_HI = 2'd2,
    ST_RAM_LO = 2'd3
  } dec_state_t;

endpackage

// File: rtl/lcd_spi_panel_rx_spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes the link into clk, detects SCK rising
// edges while CS is low and assembles MSB-first bytes with their DC flag.
module spi_byte_rx #(
  parameter int SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_mosi,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [SYNC_STG-1:0] sck_sync, cs_sync, dc_sync, mosi_sync;
  logic                sck_q;
  logic                sck_s, cs_s, dc_s, mosi_s;
  logic                sck_rise;
  logic [6:0]          shreg;
  logic [2:0]          bit_cnt;

  assign sck_s  = sck_sync[SYNC_STG-1];
  assign cs_s   = cs_sync[SYNC_STG-1];
  assign dc_s   = dc_sync[SYNC_STG-1];
  assign mosi_s = mosi_sync[SYNC_STG-1];

  // SCK edges are ignored while CS is deasserted.
  assign sck_rise = sck_s & ~sck_q & ~cs_s;

  // Synchronizer chains plus the SCK edge-detect register; CS resets to inactive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STG-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STG-2:0], spi_cs};
      dc_sync   <= {dc_sync[SYNC_STG-2:0], spi_dc};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], spi_mosi};
      sck_q     <= sck_s;
    end
  end

  // Shift in MOSI on each qualified SCK rise; the 8th bit produces a one-clk byte strobe.
  // CS high drops any partial byte by clearing the bit count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shreg   <= {shreg[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shreg, mosi_s};
          byte_dc    <= dc_s;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_panel_rx.sv
// Panel-side receiver for the 4-wire SPI LCD link: decodes the ST7789-style
// command subset and emits addressed RGB565 pixel writes.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | no command expecting data; data bytes are dropped
//   ST_ARGS   | collecting arguments of CASET/RASET/MADCTL/COLMOD
//   ST_RAM_HI | RAMWR active, waiting for pixel high byte
//   ST_RAM_LO | RAMWR active, high byte held, waiting for low byte
module lcd_spi_panel_rx
  import lcd_spi_panel_rx_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_dc,
  input  logic              spi_mosi,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] pix_x,
  output logic [ADDR_W-1:0] pix_y,
  output logic [15:0]       pix_data,
  output logic              frame_done,
  output logic              sleep_out,
  output logic              display_on,
  output logic              invert_on,
  output logic [7:0]        madctl,
  output logic [7:0]        colmod
);

  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_dc;

  dec_state_t        state;
  logic [7:0]        cur_cmd;
  logic [2:0]        arg_idx;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] xs, xe, ys, ye;
  logic [ADDR_W-1:0] cur_x, cur_y;

  spi_byte_rx #(.SYNC_STG(SYNC_STG)) u_byte_rx (
    .clk        (clk),
    .resetn     (resetn),
    .spi_clk    (spi_clk),
    .spi_cs     (spi_cs),
    .spi_dc     (spi_dc),
    .spi_mosi   (spi_mosi),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .byte_dc    (rx_dc)
  );

  // Coordinates keep only the low ADDR_W bits of the 16-bit argument (ADDR_W in 9..16).
  function automatic logic [ADDR_W-1:0] set_hi(input logic [ADDR_W-1:0] cur, input logic [7:0] b);
    return ADDR_W'({b, cur[7:0]});
  endfunction

  function automatic logic [ADDR_W-1:0] set_lo(input logic [ADDR_W-1:0] cur, input logic [7:0] b);
    return {cur[ADDR_W-1:8], b};
  endfunction

  // Decoder FSM with window/cursor and status registers; all outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      cur_cmd    <= '0;
      arg_idx    <= '0;
      hi_byte    <= '0;
      xs         <= '0;
      xe         <= '1;
      ys         <= '0;
      ye         <= '1;
      cur_x      <= '0;
      cur_y      <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      sleep_out  <= 1'b0;
      display_on <= 1'b0;
      invert_on  <= 1'b0;
      madctl     <= '0;
      colmod     <= COLMOD_RST;
    end else begin
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (rx_valid && !rx_dc) begin
        // A command always wins; a half-received pixel is simply abandoned.
        cmd_valid <= 1'b1;
        cmd_byte  <= rx_byte;
        cur_cmd   <= rx_byte;
        arg_idx   <= '0;
        state     <= ST_IDLE;
        case (rx_byte)
          OP_RAMWR: begin
            state <= ST_RAM_HI;
            cur_x <= xs;
            cur_y <= ys;
          end
          OP_CASET, OP_RASET, OP_MADCTL, OP_COLMOD: state <= ST_ARGS;
          OP_SWRESET: begin
            hi_byte    <= '0;
            xs         <= '0;
            xe         <= '1;
            ys         <= '0;
            ye         <= '1;
            cur_x      <= '0;
            cur_y      <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            sleep_out  <= 1'b0;
            display_on <= 1'b0;
            invert_on  <= 1'b0;
            madctl     <= '0;
            colmod     <= COLMOD_RST;
          end
          OP_SLPIN:   sleep_out  <= 1'b0;
          OP_SLPOUT:  sleep_out  <= 1'b1;
          OP_INVOFF:  invert_on  <= 1'b0;
          OP_INVON:   invert_on  <= 1'b1;
          OP_DISPOFF: display_on <= 1'b0;
          OP_DISPON:  display_on <= 1'b1;
          default: ;
        endcase
      end else if (rx_valid) begin
        case (state)
          ST_ARGS: begin
            // Saturate so surplus arguments fall through to the default arms.
            if (arg_idx != 3'd4) arg_idx <= arg_idx + 3'd1;
            case (cur_cmd)
              OP_CASET: begin
                case (arg_idx)
                  3'd0:    xs <= set_hi(xs, rx_byte);
                  3'd1:    xs <= set_lo(xs, rx_byte);
                  3'd2:    xe <= set_hi(xe, rx_byte);
                  3'd3:    xe <= set_lo(xe, rx_byte);
                  default: ;
                endcase
              end
              OP_RASET: begin
                case (arg_idx)
                  3'd0:    ys <= set_hi(ys, rx_byte);
                  3'd1:    ys <= set_lo(ys, rx_byte);
                  3'd2:    ye <= set_hi(ye, rx_byte);
                  3'd3:    ye <= set_lo(ye, rx_byte);
                  default: ;
                endcase
              end
              OP_MADCTL: if (arg_idx == 3'd0) madctl <= rx_byte;
              OP_COLMOD: if (arg_idx == 3'd0) colmod <= rx_byte;
              default: ;
            endcase
          end
          ST_RAM_HI: begin
            hi_byte <= rx_byte;
            state   <= ST_RAM_LO;
          end
          ST_RAM_LO: begin
            pix_valid <= 1'b1;
            pix_data  <= {hi_byte, rx_byte};
            pix_x     <= cur_x;
            pix_y     <= cur_y;
            // Raster advance; an inverted window (xs > xe) just wraps mod 2^ADDR_W.
            if (cur_x == xe) begin
              cur_x <= xs;
              if (cur_y == ye) begin
                cur_y      <= ys;
                frame_done <= 1'b1;
              end else begin
                cur_y <= cur_y + 1'b1;
              end
            end else begin
              cur_x <= cur_x + 1'b1;
            end
            state <= ST_RAM_HI;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
